// File: rtl/serv_dbus_bridge.sv
// serv_dbus_bridge: registered Wishbone classic bridge for the SERV data port.
// Captures one core request, runs a single bus transaction with a bounded
// timeout, and returns a one-cycle ack with lane-masked read data and an
// error flag. All outputs come straight from flops, so there is no
// combinational path between the core side and the SoC side.
module serv_dbus_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output logic        o_dbus_err,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // Last count value before the abort; TIMEOUT is limited to 2..65535.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 32'd1);

  // Expand the byte-lane select into a 32-bit data mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  state_t      state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdt_q, rdt_d;
  logic        err_q, err_d;
  logic        ack_q, ack_d;
  logic        cyc_q, cyc_d;
  logic        busy_q, busy_d;

  // Next-state, capture and response logic; output flops follow the next state.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    rdt_d   = rdt_q;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_dbus_cyc) begin
          adr_d   = i_dbus_adr & 32'hFFFF_FFFC;
          dat_d   = i_dbus_dat;
          sel_d   = i_dbus_sel;
          we_d    = i_dbus_we;
          cnt_d   = 16'd0;
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (i_wb_err) begin
          // Error takes priority over a simultaneous ack.
          err_d   = 1'b1;
          rdt_d   = 32'h0000_0000;
          state_d = ST_RESP;
        end else if (i_wb_ack) begin
          // An ack on the final count cycle still completes normally.
          rdt_d   = we_q ? 32'h0000_0000 : (i_wb_rdt & lane_mask(sel_q));
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          rdt_d   = 32'h0000_0000;
          state_d = ST_RESP;
        end else begin
          cnt_d   = cnt_q + 16'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_GAP;
      end
      ST_GAP: begin
        // The core drops cyc only after seeing ack, so ignore it here.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cyc_d  = (state_d == ST_REQ);
    ack_d  = (state_d == ST_RESP);
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      adr_q   <= 32'h0000_0000;
      dat_q   <= 32'h0000_0000;
      sel_q   <= 4'h0;
      we_q    <= 1'b0;
      cnt_q   <= 16'd0;
      rdt_q   <= 32'h0000_0000;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
      cyc_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      rdt_q   <= rdt_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      cyc_q   <= cyc_d;
      busy_q  <= busy_d;
    end
  end

  assign o_wb_adr   = adr_q;
  assign o_wb_dat   = dat_q;
  assign o_wb_sel   = sel_q;
  assign o_wb_we    = we_q;
  assign o_wb_cyc   = cyc_q;
  assign o_wb_stb   = cyc_q;
  assign o_dbus_ack = ack_q;
  assign o_dbus_err = err_q;
  assign o_dbus_rdt = rdt_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_serv_dbus_bridge.sv
// Bench for serv_dbus_bridge: a transaction-level model predicts every
// output each cycle, and directed scenarios pin key values with literals.
module tb_serv_dbus_bridge;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_dbus_adr = 32'h0, i_dbus_dat = 32'h0;
  logic [3:0]  i_dbus_sel = 4'h0;
  logic        i_dbus_we = 1'b0, i_dbus_cyc = 1'b0;
  logic [31:0] o_dbus_rdt;
  logic        o_dbus_ack, o_dbus_err;
  logic [31:0] o_wb_adr, o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we, o_wb_cyc, o_wb_stb;
  logic [31:0] i_wb_rdt = 32'h0;
  logic        i_wb_ack = 1'b0, i_wb_err = 1'b0;
  logic        o_busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  serv_dbus_bridge #(.TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_dbus_adr(i_dbus_adr), .i_dbus_dat(i_dbus_dat), .i_dbus_sel(i_dbus_sel),
    .i_dbus_we(i_dbus_we), .i_dbus_cyc(i_dbus_cyc),
    .o_dbus_rdt(o_dbus_rdt), .o_dbus_ack(o_dbus_ack), .o_dbus_err(o_dbus_err),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
    .o_wb_we(o_wb_we), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Keep only the bytes whose select bit is set.
  function automatic logic [31:0] keep_lanes(input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  // Model: a request is in flight, or a response is draining (2 = ack cycle, 1 = gap).
  bit          m_req;
  int          m_post;
  int          m_wait;
  logic [31:0] m_adr, m_dat, m_rdt;
  logic [3:0]  m_sel;
  logic        m_we, m_err;

  always @(posedge clk) begin
    if (i_rst) begin
      m_req <= 1'b0; m_post <= 0; m_wait <= 0;
      m_adr <= 32'h0; m_dat <= 32'h0; m_sel <= 4'h0; m_we <= 1'b0;
      m_rdt <= 32'h0; m_err <= 1'b0;
    end else if (m_req) begin
      if (i_wb_err || (!i_wb_ack && m_wait == TMO - 1)) begin
        m_req <= 1'b0; m_post <= 2; m_err <= 1'b1; m_rdt <= 32'h0;
      end else if (i_wb_ack) begin
        m_req <= 1'b0; m_post <= 2; m_err <= 1'b0;
        m_rdt <= m_we ? 32'h0 : keep_lanes(i_wb_rdt, m_sel);
      end else begin
        m_wait <= m_wait + 1;
      end
    end else if (m_post != 0) begin
      m_post <= m_post - 1;
    end else if (i_dbus_cyc) begin
      m_req <= 1'b1; m_wait <= 0;
      m_adr <= {i_dbus_adr[31:2], 2'b00}; m_dat <= i_dbus_dat;
      m_sel <= i_dbus_sel; m_we <= i_dbus_we;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("wb_cyc_stb", 64'({o_wb_cyc, o_wb_stb}), 64'({m_req, m_req}));
      chk("wb_adr", 64'(o_wb_adr), 64'(m_adr));
      chk("wb_dat_sel_we", 64'({o_wb_dat, o_wb_sel, o_wb_we}), 64'({m_dat, m_sel, m_we}));
      chk("dbus_ack_err_rdt", 64'({o_dbus_ack, o_dbus_err, o_dbus_rdt}),
          64'({(m_post == 2), (m_post == 2) && m_err, m_rdt}));
      chk("busy", 64'(o_busy), 64'(m_req || (m_post != 0)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request to an idle bridge; returns in the first REQ cycle.
  task automatic start(input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic we);
    i_dbus_adr = adr; i_dbus_dat = dat; i_dbus_sel = sel; i_dbus_we = we;
    i_dbus_cyc = 1'b1;
    tick();
  endtask

  // Serve the bus request (kind 0 ack, 1 err, 2 ack+err, 3 silent) after
  // 'waits' wait states; returns in the cycle after GAP.
  task automatic run(input int waits, input int kind, input logic [31:0] rdata,
                     input bit hold, output int ncyc, output logic [31:0] adr_snap,
                     output logic ack, output logic err, output logic [31:0] rdt,
                     output logic gap_ack, output logic gap_cyc, output logic idle_cyc);
    ncyc = 0;
    adr_snap = 32'hx;
    while (o_wb_cyc && ncyc < 100) begin
      if (ncyc == 0) adr_snap = o_wb_adr;
      i_wb_ack = (kind == 0 || kind == 2) && (ncyc == waits);
      i_wb_err = (kind == 1 || kind == 2) && (ncyc == waits);
      i_wb_rdt = rdata;
      ncyc++;
      tick();
      i_wb_ack = 1'b0; i_wb_err = 1'b0;
    end
    if (ncyc >= 100) chk("cyc_bound", 64'(ncyc), 64'(99));
    ack = o_dbus_ack; err = o_dbus_err; rdt = o_dbus_rdt;
    if (!hold) i_dbus_cyc = 1'b0;
    i_dbus_adr = 32'hDEAD_BEEF; i_dbus_dat = 32'hFFFF_FFFF;
    tick();
    gap_ack = o_dbus_ack; gap_cyc = o_wb_cyc;
    tick();
    idle_cyc = o_wb_cyc;
  endtask

  initial begin
    int n;
    logic [31:0] a, r;
    logic ak, er, ga, gc, ic;

    tick();
    started = 1'b1;
    tick();
    chk("reset_outputs", 64'({o_wb_cyc, o_wb_stb, o_dbus_ack, o_dbus_err, o_busy, o_dbus_rdt}), 64'h0);
    i_rst = 1'b0;
    tick();

    // Zero-wait read with upper lanes selected.
    start(32'h0000_1006, 32'h0, 4'b1100, 1'b0);
    run(0, 0, 32'hAABB_CCDD, 1'b0, n, a, ak, er, r, ga, gc, ic);
    chk("rd0_ncyc", 64'(n), 64'd1);
    chk("rd0_adr", 64'(a), 64'h0000_1004);
    chk("rd0_ack_err", 64'({ak, er}), 64'b10);
    chk("rd0_rdt", 64'(r), 64'hAABB_0000);
    chk("rd0_ack_one_cycle", 64'(ga), 64'd0);

    // Write with three wait states.
    start(32'h0000_0010, 32'h1234_5678, 4'b1111, 1'b1);
    run(3, 0, 32'h5555_5555, 1'b0, n, a, ak, er, r, ga, gc, ic);
    chk("wr3_ncyc", 64'(n), 64'd4);
    chk("wr3_resp", 64'({ak, er, r}), 64'({1'b1, 1'b0, 32'h0}));

    // Silent slave: abort after TIMEOUT cycles.
    start(32'h0000_0040, 32'h0, 4'b1111, 1'b0);
    run(0, 3, 32'h7777_7777, 1'b0, n, a, ak, er, r, ga, gc, ic);
    chk("tmo_ncyc", 64'(n), 64'd8);
    chk("tmo_resp", 64'({ak, er, r}), 64'({1'b1, 1'b1, 32'h0}));

    // Next request after a timeout works normally.
    start(32'h0000_0020, 32'h0, 4'b0011, 1'b0);
    run(1, 0, 32'h1122_3344, 1'b0, n, a, ak, er, r, ga, gc, ic);
    chk("post_tmo_ncyc", 64'(n), 64'd2);
    chk("post_tmo_resp", 64'({ak, er, r}), 64'({1'b1, 1'b0, 32'h0000_3344}));

    // Ack and err together: err wins.
    start(32'h0000_0030, 32'h0, 4'b1111, 1'b0);
    run(0, 2, 32'h9999_9999, 1'b0, n, a, ak, er, r, ga, gc, ic);
    chk("both_resp", 64'({ak, er, r}), 64'({1'b1, 1'b1, 32'h0}));

    // Ack on the last count cycle: ack wins.
    start(32'h0000_0034, 32'h0, 4'b1111, 1'b0);
    run(7, 0, 32'hCAFE_F00D, 1'b0, n, a, ak, er, r, ga, gc, ic);
    chk("late_ack_ncyc", 64'(n), 64'd8);
    chk("late_ack_resp", 64'({ak, er, r}), 64'({1'b1, 1'b0, 32'hCAFE_F00D}));

    // Plain bus error on a write after two wait states.
    start(32'h0000_0038, 32'hA5A5_A5A5, 4'b0001, 1'b1);
    run(2, 1, 32'h0, 1'b0, n, a, ak, er, r, ga, gc, ic);
    chk("err_ncyc", 64'(n), 64'd3);
    chk("err_resp", 64'({ak, er, r}), 64'({1'b1, 1'b1, 32'h0}));

    // Reset in the third REQ cycle, then a stray ack.
    start(32'h0000_0050, 32'h0, 4'b1111, 1'b0);
    tick();
    tick();
    chk("rst_in_req", 64'(o_wb_cyc), 64'd1);
    i_rst = 1'b1; i_dbus_cyc = 1'b0;
    tick();
    chk("rst_outputs", 64'({o_wb_cyc, o_wb_stb, o_dbus_ack, o_dbus_err, o_busy, o_wb_adr, o_dbus_rdt}), 64'h0);
    i_rst = 1'b0; i_wb_ack = 1'b1; i_wb_rdt = 32'h1234_0000;
    tick();
    i_wb_ack = 1'b0;
    chk("stray_ack", 64'({o_dbus_ack, o_busy}), 64'h0);
    tick();
    chk("stray_ack_late", 64'({o_dbus_ack, o_busy}), 64'h0);

    // Held cyc: nothing in GAP, one new transaction launched from IDLE.
    start(32'h0000_0060, 32'h0, 4'b0101, 1'b0);
    run(0, 0, 32'h5A5A_A5A5, 1'b1, n, a, ak, er, r, ga, gc, ic);
    chk("hold_resp", 64'({ak, er, r}), 64'({1'b1, 1'b0, 32'h005A_00A5}));
    chk("hold_gap_cyc", 64'(gc), 64'd0);
    chk("hold_idle_cyc", 64'(ic), 64'd0);
    tick();
    chk("hold_relaunch", 64'(o_wb_cyc), 64'd1);
    run(0, 0, 32'h0102_0304, 1'b0, n, a, ak, er, r, ga, gc, ic);
    chk("hold_second", 64'({n[7:0], ak, er, r}), 64'({8'd1, 1'b1, 1'b0, 32'h0002_0004}));
    chk("hold_no_third", 64'(ic), 64'd0);
    tick();
    chk("hold_idle_end", 64'({o_wb_cyc, o_busy}), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
